// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the framed UART receiver.
//   - uart_rx_state_t       : receiver FSM states
//   - UART_MIN_CLKS_PER_BIT : smallest bit period the sampler can centre on
//   - majority3()           : 2-of-3 vote used for every bit decision
// Build option: UART_PARITY_EN adds the PARITY state.
// ---------------------------------------------------------------------------
package uart_pkg;

    // Below this the H-1/H/H+1 sample points crowd the bit edges.
    localparam int UART_MIN_CLKS_PER_BIT = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } uart_rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler
// Synchronises the raw serial line and produces the per-bit majority vote.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   i_rx         : raw asynchronous serial line (idle high)
//   i_bitCnt     : bit-period counter from the receiver FSM
//   o_fallEdge   : synchronised high-to-low transition of a line seen high
//   o_majority   : 2-of-3 vote of samples at H-1, H, H+1; meaningful only
//                  in the cycle where i_bitCnt == H+1
// Build option: none (UART_PARITY_EN does not affect this file).
// ---------------------------------------------------------------------------
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int CNT_W = 4,
    parameter int HALF  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_rx,
    input  logic [CNT_W-1:0] i_bitCnt,
    output logic             o_fallEdge,
    output logic             o_majority
);

    localparam logic [CNT_W-1:0] CNT_A = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_B = CNT_W'(HALF);

    logic       r_meta;
    logic       r_sync;
    logic       r_syncPrev;
    logic       r_seenHigh;
    logic [1:0] r_fill;
    logic       r_sampleA;
    logic       r_sampleB;

    // Two-flop synchroniser; both stages idle high out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_rx;
            r_sync <= r_meta;
        end
    end

    // The synchroniser's reset value is not a real observation of the line,
    // so r_fill tracks when r_sync first carries genuine line data. Edges are
    // only armed once the line has truly been seen high after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fill     <= 2'b00;
            r_syncPrev <= 1'b1;
            r_seenHigh <= 1'b0;
        end else begin
            r_fill     <= {r_fill[0], 1'b1};
            r_syncPrev <= r_sync;
            if (r_fill[1] && r_sync) begin
                r_seenHigh <= 1'b1;
            end
        end
    end

    // The first two votes are stored; the third is the live synchronised
    // value at H+1, so the decision is ready in that very cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sampleA <= 1'b1;
            r_sampleB <= 1'b1;
        end else begin
            if (i_bitCnt == CNT_A) begin
                r_sampleA <= r_sync;
            end
            if (i_bitCnt == CNT_B) begin
                r_sampleB <= r_sync;
            end
        end
    end

    assign o_fallEdge = r_seenHigh & r_syncPrev & ~r_sync;
    assign o_majority = majority3(r_sampleA, r_sampleB, r_sync);

endmodule

// File: rtl/uart_rx_framed.sv
// ---------------------------------------------------------------------------
// uart_rx_framed
// UART receiver with majority-vote sampling, framing/parity checks, a
// one-entry valid/ready holding register and a sticky overrun flag.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   rx         : asynchronous serial line, idle high, LSB first
//   rx_data    : received word (held while rx_valid && !rx_ready)
//   rx_valid   : holding register contains an unconsumed frame
//   rx_ready   : consumer accepts the frame when rx_valid && rx_ready
//   frame_err  : a stop bit of the held frame sampled low
//   parity_err : parity mismatch on the held frame
//   overrun    : sticky, a frame was dropped because the holder was full
//   busy       : FSM is not IDLE
// Build option: define UART_PARITY_EN to expect and check one parity bit
// (odd/even selected by PARITY_ODD); otherwise parity_err is tied low.
// ---------------------------------------------------------------------------
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CLKS_EFF = (CLKS_PER_BIT < UART_MIN_CLKS_PER_BIT) ?
                              UART_MIN_CLKS_PER_BIT : CLKS_PER_BIT;
    localparam int CNT_W    = $clog2(CLKS_EFF);
    localparam int HALF     = CLKS_EFF / 2;
    localparam int IDX_W    = 4;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_EFF - 1);
    localparam logic [CNT_W-1:0] CNT_MAJ   = CNT_W'(HALF + 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    uart_rx_state_t       r_state;
    uart_rx_state_t       w_nextState;
    logic [CNT_W-1:0]     r_bitCnt;
    logic [IDX_W-1:0]     r_bitIdx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_frmErrAcc;

    logic w_fallEdge;
    logic w_majority;
    logic w_bitEnd;
    logic w_majPoint;
    logic w_shiftEn;
    logic w_stopCheck;
    logic w_frameDone;
`ifdef UART_PARITY_EN
    logic r_parErr;
    logic w_parityEn;
`endif

    uart_rx_sampler #(
        .CNT_W (CNT_W),
        .HALF  (HALF)
    ) u_sampler (
        .clk        (clk),
        .reset      (reset),
        .i_rx       (rx),
        .i_bitCnt   (r_bitCnt),
        .o_fallEdge (w_fallEdge),
        .o_majority (w_majority)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. STOP exits at the vote point of the last stop bit
    // rather than at its end, so an immediately following start edge is seen.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_fallEdge) begin
                    w_nextState = START;
                end
            end
            START: begin
                if (w_majPoint && w_majority) begin
                    w_nextState = IDLE;
                end else if (w_bitEnd) begin
                    w_nextState = DATA;
                end
            end
            DATA: begin
                if (w_bitEnd && (r_bitIdx == DATA_LAST)) begin
`ifdef UART_PARITY_EN
                    w_nextState = PARITY;
`else
                    w_nextState = STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (w_bitEnd) begin
                    w_nextState = STOP;
                end
            end
`endif
            STOP: begin
                if (w_majPoint && (r_bitIdx == STOP_LAST)) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Output / strobe decode.
    always_comb begin
        busy        = (r_state != IDLE);
        w_bitEnd    = (r_bitCnt == CNT_LAST);
        w_majPoint  = (r_bitCnt == CNT_MAJ);
        w_shiftEn   = (r_state == DATA) && w_majPoint;
        w_stopCheck = (r_state == STOP) && w_majPoint;
        w_frameDone = w_stopCheck && (r_bitIdx == STOP_LAST);
`ifdef UART_PARITY_EN
        w_parityEn  = (r_state == PARITY) && w_majPoint;
`endif
    end

    // Bit-period counter restarts on every state change and at the end of
    // each period; it stays at zero in IDLE so no votes are taken there.
    // r_bitIdx counts data bits in DATA and stop bits in STOP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bitCnt <= '0;
            r_bitIdx <= '0;
        end else begin
            if ((w_nextState != r_state) || w_bitEnd) begin
                r_bitCnt <= '0;
            end else if (r_state != IDLE) begin
                r_bitCnt <= r_bitCnt + 1'b1;
            end

            if (w_nextState != r_state) begin
                r_bitIdx <= '0;
            end else if (w_bitEnd && ((r_state == DATA) || (r_state == STOP))) begin
                r_bitIdx <= r_bitIdx + 1'b1;
            end
        end
    end

    // Frame assembly: data shifts in from the top so the first bit on the
    // line ends up in bit 0. Error accumulators restart while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift     <= '0;
            r_frmErrAcc <= 1'b0;
`ifdef UART_PARITY_EN
            r_parErr    <= 1'b0;
`endif
        end else begin
            if (w_shiftEn) begin
                r_shift <= {w_majority, r_shift[DATA_BITS-1:1]};
            end

            if (r_state == IDLE) begin
                r_frmErrAcc <= 1'b0;
            end else if (w_stopCheck && !w_majority) begin
                r_frmErrAcc <= 1'b1;
            end

`ifdef UART_PARITY_EN
            if (r_state == IDLE) begin
                r_parErr <= 1'b0;
            end else if (w_parityEn) begin
                r_parErr <= (^r_shift) ^ w_majority ^ PARITY_ODD[0];
            end
`endif
        end
    end

    // Holding register. A finished frame loads if the holder is empty or is
    // being handed off this cycle; otherwise it is dropped and overrun sticks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            if (w_frameDone && (!rx_valid || rx_ready)) begin
                rx_data    <= r_shift;
                rx_valid   <= 1'b1;
                frame_err  <= r_frmErrAcc | ~w_majority;
`ifdef UART_PARITY_EN
                parity_err <= r_parErr;
`endif
            end else begin
                if (w_frameDone) begin
                    overrun <= 1'b1;
                end
                if (rx_valid && rx_ready) begin
                    rx_valid <= 1'b0;
                end
            end
        end
    end

`ifndef UART_PARITY_EN
    // No parity bit exists on the line, so the flag stays clear whatever
    // PARITY_ODD is set to.
    assign parity_err = 1'b0 & PARITY_ODD[0];
`endif

endmodule

// File: tb/tb_uart_rx_framed.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_framed
// Self-checking bench for uart_rx_framed (CLKS_PER_BIT=16, 8 data bits,
// 1 stop bit, even parity). Frames are serialised by applyStimulus, which
// pushes the expected word and flags into a scoreboard; a monitor pops and
// compares on every rx_valid && rx_ready handshake.
// Build option: UART_PARITY_EN adds the parity bit to the serialised frame.
// ---------------------------------------------------------------------------
module tb_uart_rx_framed;

    localparam int CLKS       = 16;
    localparam int PARITY_ODD = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       busy;

    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];
    bit   randReady  = 1'b0;
    logic readyForce = 1'b1;

    uart_rx_framed #(
        .CLKS_PER_BIT (CLKS),
        .DATA_BITS    (8),
        .STOP_BITS    (1),
        .PARITY_ODD   (PARITY_ODD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Reference rule: even/odd parity holds when data ones + parity bit
    // + PARITY_ODD is even.
    function automatic logic goodParity(input logic [7:0] d);
        return 1'(($countones(d) + PARITY_ODD) % 2);
    endfunction

    function automatic logic parityError(input logic [7:0] d, input logic p);
`ifdef UART_PARITY_EN
        return 1'((($countones(d) + int'(p) + PARITY_ODD) % 2) != 0);
`else
        return 1'b0 & p;
`endif
    endfunction

    task automatic driveBit(input logic b);
        rx = b;
        repeat (CLKS) @(posedge clk);
        #1;
    endtask

    task automatic idleLine(input int cycles);
        rx = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic p,
                                 input logic stopBit, input bit doPush);
        exp_t e;
        if (doPush) begin
            e.data = d;
            e.ferr = ~stopBit;
            e.perr = parityError(d, p);
            expQ.push_back(e);
        end
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) begin
            driveBit(d[i]);
        end
`ifdef UART_PARITY_EN
        driveBit(p);
`endif
        driveBit(stopBit);
    endtask

    task automatic waitDrain(input int limit);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput("scoreboard drain", expQ.size(), 0);
    endtask

    // Consumer: rx_ready is either forced or randomly throttled.
    initial begin
        rx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rx_ready = randReady ? 1'($urandom_range(0, 3) != 0) : readyForce;
        end
    end

    // Monitor: compares handshaked frames with the scoreboard and checks
    // that a stalled frame does not change under the consumer.
    initial begin
        exp_t       e;
        bit         prevHeld;
        logic [7:0] prevData;
        logic [1:0] prevFlags;
        prevHeld  = 1'b0;
        prevData  = '0;
        prevFlags = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prevHeld = 1'b0;
            end else begin
                if (prevHeld) begin
                    checkOutput("held rx_data stable", rx_data, prevData);
                    checkOutput("held flags stable", {frame_err, parity_err}, prevFlags);
                end
                if (rx_valid && rx_ready) begin
                    checkOutput("frame was expected", expQ.size() > 0, 1);
                    if (expQ.size() > 0) begin
                        e = expQ.pop_front();
                        checkOutput("rx_data", rx_data, e.data);
                        checkOutput("frame_err", frame_err, e.ferr);
                        checkOutput("parity_err", parity_err, e.perr);
                    end
                end
                prevHeld  = rx_valid && !rx_ready;
                prevData  = rx_data;
                prevFlags = {frame_err, parity_err};
            end
        end
    end

    initial begin
        logic [7:0] d;
        logic       p;
        logic       s;
        bit         sawBusy;

        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset rx_valid", rx_valid, 0);
        checkOutput("reset rx_data", rx_data, 0);
        checkOutput("reset frame_err", frame_err, 0);
        checkOutput("reset parity_err", parity_err, 0);
        checkOutput("reset overrun", overrun, 0);
        checkOutput("reset busy", busy, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idleLine(20);

        // Clean 0x5A, then check rx_valid was a single-cycle pulse.
        applyStimulus(8'h5A, goodParity(8'h5A), 1'b1, 1'b1);
        waitDrain(100);
        @(negedge clk);
        checkOutput("rx_valid one-cycle pulse", rx_valid, 0);
        idleLine(10);

        // 0x5A with the wrong parity bit.
        applyStimulus(8'h5A, ~goodParity(8'h5A), 1'b1, 1'b1);
        waitDrain(100);
        idleLine(10);

        // 0xA5 with a low stop bit, then a clean 0x3C.
        applyStimulus(8'hA5, goodParity(8'hA5), 1'b0, 1'b1);
        idleLine(8);
        applyStimulus(8'h3C, goodParity(8'h3C), 1'b1, 1'b1);
        waitDrain(100);
        idleLine(10);

        // Four-cycle glitch on an idle line.
        sawBusy = 1'b0;
        rx = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 4) begin
                rx = 1'b1;
            end
            @(negedge clk);
            if (busy) sawBusy = 1'b1;
        end
        checkOutput("glitch started receiver", sawBusy, 1);
        checkOutput("glitch busy cleared", busy, 0);
        idleLine(20);

        // Randomised frames with a throttled consumer.
        randReady = 1'b1;
        for (int n = 0; n < 20; n++) begin
            d = 8'($urandom_range(0, 255));
            p = ($urandom_range(0, 3) == 0) ? ~goodParity(d) : goodParity(d);
            s = ($urandom_range(0, 6) != 0);
            applyStimulus(d, p, s, 1'b1);
            idleLine(s ? $urandom_range(0, 20) : $urandom_range(4, 20));
        end
        randReady  = 1'b0;
        readyForce = 1'b1;
        waitDrain(200);
        idleLine(10);

        // Overrun: consumer stalls while two frames arrive back-to-back.
        readyForce = 1'b0;
        idleLine(3);
        applyStimulus(8'h11, goodParity(8'h11), 1'b1, 1'b1);
        applyStimulus(8'h22, goodParity(8'h22), 1'b1, 1'b0);
        idleLine(5);
        @(negedge clk);
        checkOutput("overrun set", overrun, 1);
        checkOutput("held rx_valid", rx_valid, 1);
        checkOutput("held first frame", rx_data, 8'h11);
        readyForce = 1'b1;
        waitDrain(50);
        @(negedge clk);
        checkOutput("rx_valid after handshake", rx_valid, 0);
        checkOutput("overrun sticky", overrun, 1);
        idleLine(10);

        // Reset in the middle of the data bits of 0x77, line held low after.
        driveBit(1'b0);
        for (int i = 0; i < 3; i++) begin
            driveBit(1'b1);
        end
        rx = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        checkOutput("busy mid-frame", busy, 1);
        reset = 1'b1;
        #1;
        checkOutput("async reset busy", busy, 0);
        checkOutput("async reset rx_valid", rx_valid, 0);
        checkOutput("async reset rx_data", rx_data, 0);
        checkOutput("async reset frame_err", frame_err, 0);
        checkOutput("async reset parity_err", parity_err, 0);
        checkOutput("async reset overrun", overrun, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        sawBusy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) sawBusy = 1'b1;
        end
        checkOutput("low line after reset ignored", sawBusy, 0);
        idleLine(20);
        checkOutput("idle after line rises", busy, 0);
        applyStimulus(8'h3C, goodParity(8'h3C), 1'b1, 1'b1);
        waitDrain(100);
        idleLine(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_framed.md
UART_RX_FRAMED -- requirements
Module: uart_rx_framed

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per bit (100 MHz / 115200); legal 8..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal 5..9.
REQ-003 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked per frame; legal 1 or 2.
REQ-004 SHALL have parameter PARITY_ODD, default 0, meaning 0 = even parity, 1 = odd parity; used only when UART_PARITY_EN is defined.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic on posedge.
REQ-006 SHALL have port reset, input, 1, meaning the reset; it is asynchronous and active-high.
REQ-007 SHALL have port rx, input, 1, meaning the asynchronous serial line, idle high.
REQ-008 SHALL have port rx_data, output, DATA_BITS, meaning the received word, LSB first on the line.
REQ-009 SHALL have port rx_valid, output, 1, meaning rx_data and the error flags hold an unconsumed frame.
REQ-010 SHALL have port rx_ready, input, 1, meaning the consumer accepts the frame when rx_valid && rx_ready.
REQ-011 SHALL have port frame_err, output, 1, meaning a stop bit of the held frame sampled low.
REQ-012 SHALL have port parity_err, output, 1, meaning parity mismatch on the held frame.
REQ-013 SHALL have port overrun, output, 1, meaning sticky: a frame was dropped because the holding register was full.
REQ-014 SHALL have port busy, output, 1, meaning the FSM is not in IDLE.

Function
REQ-015 SHALL pass rx through a 2-flop synchroniser (reset value 1) before any use; all latency figures are measured from the synchronised line.
REQ-016 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-017 SHALL make each bit decision by a 2-of-3 majority of samples at counter values H-1, H and H+1 (H = CLKS_PER_BIT/2) within the bit period.
REQ-018 SHALL use a bit-period counter that is CLKS_PER_BIT wide-enough, wraps at CLKS_PER_BIT-1, and clears on every state entry.
REQ-019 SHALL go IDLE->START on a synchronised falling edge.
REQ-020 SHALL go START->IDLE (glitch rejected, nothing reported) if the start-bit majority is 1; otherwise it SHALL go START->DATA at the end of the bit period.
REQ-021 SHALL shift DATA_BITS bits into a shift register LSB first, then go to PARITY (macro defined) or STOP.
REQ-022 SHALL in PARITY compute XOR(data, parity bit) ^ PARITY_ODD; a nonzero result SHALL set the frame's parity error.
REQ-023 SHALL in STOP check STOP_BITS stop bits; any low majority SHALL set the frame's framing error.
REQ-024 SHALL leave STOP for IDLE at the majority point of the last stop bit, not at its end, so a back-to-back start edge is caught.
REQ-025 SHALL, when leaving STOP with the holding register empty or being consumed that cycle, load rx_data, frame_err and parity_err, and assert rx_valid on the next cycle.
REQ-026 SHALL, when leaving STOP with rx_valid=1 and rx_ready=0, discard the new frame, set overrun, and leave the held frame unchanged.
REQ-027 SHALL clear overrun only by reset.
REQ-028 SHALL deassert rx_valid the cycle after a handshake unless a new frame loads in the same cycle, in which case rx_valid stays 1.
REQ-029 SHALL keep rx_data and the error flags stable while rx_valid=1 and rx_ready=0.

Reset
REQ-030 SHALL, on reset assertion, immediately force state IDLE, rx_valid 0, rx_data 0, frame_err 0, parity_err 0, overrun 0, busy 0, counters 0 and synchroniser 1.
REQ-031 SHALL abandon any frame in progress on reset without reporting it.
REQ-032 SHALL, after reset deassertion, ignore a line held low until it has been seen high, so reception resumes only on a true falling edge.

Configuration
REQ-033 SHALL, with UART_PARITY_EN defined, expect one parity bit after the data bits and check it per PARITY_ODD.
REQ-034 SHALL, without UART_PARITY_EN, compile out the PARITY state and the parity logic and tie parity_err to 0.

Structure
REQ-035 SHALL place the FSM state enum (uart_rx_state_t) and the minimum-CLKS_PER_BIT constant in shared package uart_pkg.
REQ-036 SHALL implement the synchroniser plus 3-sample majority voter as sub-module uart_rx_sampler.

Verification (CLKS_PER_BIT=16, DATA_BITS=8, STOP_BITS=1, UART_PARITY_EN defined, PARITY_ODD=0)
REQ-037 SHALL cover: frame 0x5A, even parity 0, stop 1, rx_ready=1 -> rx_valid pulses 1 cycle, rx_data=0x5A, both error flags 0.
REQ-038 SHALL cover: frame 0x5A with parity bit 1 -> rx_valid with parity_err=1, rx_data=0x5A.
REQ-039 SHALL cover: frame 0xA5 with stop bit 0 -> frame_err=1; a following 0x3C frame is received cleanly.
REQ-040 SHALL cover: a 4-cycle low glitch on an idle line -> no rx_valid and busy returns to 0 within 16 cycles.
REQ-041 SHALL cover: rx_ready=0 while frames 0x11 then 0x22 arrive back-to-back -> rx_data=0x11 is held and overrun=1; after a handshake rx_valid=0 and overrun stays 1.
REQ-042 SHALL cover: reset asserted mid-DATA of frame 0x77, with the line held low after release -> outputs at reset values, no frame reported until the next true falling edge.
